wb_commit_unit: RTL

//   Registered, parametrised write-back/commit stage for the 5-stage RV64 core.

---
 rtl/wb_commit_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: one-hot result select, a single commit register feeding the
// regfile write port, a retired-instruction counter and a sticky select-error flag.
module wb_commit_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NSRC   = 4,
    parameter int unsigned PC_SRC = 1,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_INC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_wen,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic [NSRC-1:0]        in_sel,
    input  logic [NSRC*XLEN-1:0]   in_data,
    input  logic                   stall,
    output logic                   rf_wen,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [63:0]            instret,
    output logic                   sel_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [63:0]         instret_q, instret_d;
    logic                sel_err_q, sel_err_d;

    logic [XLEN-1:0]     mux_data;
    logic [XLEN-1:0]     src;
    logic                sel_onehot;
    logic                accept;
    logic                retire;

    // AND-OR result mux; the PC slot carries the link value pc+PC_INC
    always_comb begin
        mux_data = '0;
        src      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            src = in_data[k*XLEN +: XLEN];
            if (k == PC_SRC) begin
                src = src + XLEN'(PC_INC);
            end
            mux_data = mux_data | ({XLEN{in_sel[k]}} & src);
        end
    end

    assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - NSRC'(1))) == '0);

    // Next-state, handshake and commit-entry update
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        instret_d = instret_q;
        sel_err_d = sel_err_q;

        in_ready = (state_q == EMPTY) || !stall;
        accept   = in_valid && in_ready;
        retire   = (state_q == HELD) && !stall;
        rf_wen   = (state_q == HELD) && wr_q && !stall;

        case (state_q)
            EMPTY: if (accept) state_d = HELD;
            HELD:  if (!stall) state_d = accept ? HELD : EMPTY;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            wr_d    = in_wen && (in_rd != '0) && sel_onehot;
            waddr_d = in_rd;
            wdata_d = mux_data;
            if (in_wen && !sel_onehot) begin
                sel_err_d = 1'b1;
            end
        end

        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            instret_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            instret_q <= instret_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign instret  = instret_q;
    assign sel_err  = sel_err_q;

endmodule
